fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Produces InstrF, PC_4F, ExcCodeF and if_bdF, which the F/D pipeline register latches.
- Handles stall, D-stage branch/jump redirect, exception entry, eret return, and fetch address-error (AdEL) detection.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFF, highest legal fetch byte address (inclusive).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- EN  in  1  1 = PC may advance; 0 = stall, hold PC
- redirect_D  in  1  branch taken or jump in D this cycle
- redirect_pc_D  in  32  target for redirect_D
- is_jb_D  in  1  instruction currently in D is a branch/jump
- exc_req  in  1  exception/interrupt accepted (from CP0)
- eret_req  in  1  eret committed (from CP0)
- epc  in  32  return address for eret_req
- im_addr  out  32  instruction-memory byte address (= PC_F)
- im_rdata  in  32  instruction word returned combinationally for im_addr
- PC_F  out  32  current fetch PC
- InstrF  out  32  fetched instruction (0 when fetch faults)
- PC_4F  out  32  PC_F + 4
- ExcCodeF  out  [6:2]  5'd4 (AdEL) on fetch fault, else 5'd0
- if_bdF  out  1  instruction in F is a delay slot

Behaviour:
- PC register updates on posedge clk. The next value is chosen by this priority:
  1. reset: PC <= PC_RESET
  2. exc_req: PC <= EXC_ENTRY (ignores EN)
  3. eret_req: PC <= epc (ignores EN)
  4. EN == 0: PC holds
  5. redirect_D: PC <= redirect_pc_D
  6. otherwise: PC <= PC + 4
- exc_req and eret_req together: exc_req wins.
- Reset values: PC_F = im_addr = PC_RESET; PC_4F = PC_RESET + 4; ExcCodeF = 0; if_bdF = 0 while reset is sampled and on the first cycle after.
- Arithmetic: PC + 4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0, and that address then faults.
- Fetch fault: fault = (PC_F[1:0] != 0) | (PC_F < IM_BASE) | (PC_F > IM_LIMIT), evaluated combinationally.
  - On fault: InstrF = 32'h0, ExcCodeF = 5'd4.
  - Otherwise: InstrF = im_rdata, ExcCodeF = 5'd0.
- Faulting PC: the PC keeps advancing normally (+4 or redirect). The exception is taken later via exc_req.
- redirect_pc_D: not checked here; misaligned targets fault on the next fetch.
- Delay-slot tracking:
  - Registered flag bd_q. On a cycle with EN = 1 and no exc_req/eret_req, bd_q <= is_jb_D; on EN = 0, bd_q holds.
  - if_bdF = bd_q & ~first_after_redirect_exc, where the exc/eret redirect cycle clears bd_q to 0.
  - Sampling at the EN edge means a stalled delay slot keeps its flag.
- Latency: a redirect_D, exc_req or eret_req asserted in cycle N is visible on PC_F in cycle N+1. No bubbles are inserted here; flushing is done by the pipeline register's CLR.
- Reset mid-operation overrides all pending requests in the same cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined, two additional outputs are present:
  - fetch_cnt [31:0]: increments on each cycle with EN = 1 and no reset/exc_req/eret_req.
  - stall_cnt [31:0]: increments on each cycle with EN = 0 and no reset/exc_req/eret_req.
  - Both are 0 after reset and wrap modulo 2^32.
- Without the macro: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Reset then 3 cycles with EN = 1 -> PC_F sequence 0x3000, 0x3004, 0x3008, 0x300C; PC_4F = PC_F + 4; ExcCodeF = 0.
- EN = 0 for 2 cycles at PC 0x3010 -> PC_F stays 0x3010; InstrF stable; then EN = 1 -> 0x3014.
- redirect_D = 1, redirect_pc_D = 0x3100, is_jb_D = 1 at PC 0x3020 -> next PC_F = 0x3100 with if_bdF = 1; the following instruction has if_bdF = 0.
- exc_req asserted together with EN = 0 and redirect_D = 1 -> next PC_F = 0x4180, if_bdF = 0; eret_req with epc = 0x3024 -> next PC_F = 0x3024.
- redirect_pc_D = 0x3002 -> InstrF = 0, ExcCodeF = 4; redirect to 0x7000 -> ExcCodeF = 4; PC 0x6FFC -> ExcCodeF = 0.
- With FETCH_PERF_CNT_EN: 5 run cycles and 3 stall cycles after reset -> fetch_cnt = 5, stall_cnt = 3; reset mid-count -> both 0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage control inputs, instruction-memory port and F/D outputs.
interface fetch_pc_unit_if;
    logic        EN;
    logic        redirect_D;
    logic [31:0] redirect_pc_D;
    logic        is_jb_D;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] PC_F;
    logic [31:0] InstrF;
    logic [31:0] PC_4F;
    logic [6:2]  ExcCodeF;
    logic        if_bdF;
    modport master (
        input  EN, redirect_D, redirect_pc_D, is_jb_D, exc_req, eret_req, epc, im_rdata,
        output im_addr, PC_F, InstrF, PC_4F, ExcCodeF, if_bdF
    );
    modport slave (
        output EN, redirect_D, redirect_pc_D, is_jb_D, exc_req, eret_req, epc, im_rdata,
        input  im_addr, PC_F, InstrF, PC_4F, ExcCodeF, if_bdF
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: MIPS fetch PC with stall, redirect, exception/eret entry and AdEL detection.
// Defining FETCH_PERF_CNT_EN adds the fetch_cnt/stall_cnt performance counters.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFF
) (
    input  logic clk,
    input  logic reset,
    fetch_pc_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic        fault;
    logic        cp0_redir;
    assign cp0_redir = bus.exc_req | bus.eret_req;
    always_comb begin
        pc_d = bus.exc_req    ? EXC_ENTRY :
               bus.eret_req   ? bus.epc :
               !bus.EN        ? pc_q :
               bus.redirect_D ? bus.redirect_pc_D : pc_q + 32'd4;
        bd_d = cp0_redir ? 1'b0 : bus.EN ? bus.is_jb_D : bd_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
            bd_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            bd_q <= bd_d;
        end
    end
    assign fault        = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_LIMIT);
    assign bus.im_addr  = pc_q;
    assign bus.PC_F     = pc_q;
    assign bus.PC_4F    = pc_q + 32'd4;
    assign bus.InstrF   = fault ? 32'h0 : bus.im_rdata;
    assign bus.ExcCodeF = fault ? 5'd4 : 5'd0;
    assign bus.if_bdF   = bd_q & ~reset;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (!cp0_redir) begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, bus.EN};
            stall_cnt_q <= stall_cnt_q + {31'd0, ~bus.EN};
        end
    end
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plus random checks of fetch_pc_unit against a behavioural model.
module tb_fetch_pc_unit;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFF;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_pc, m_fc, m_sc;
    logic        m_bd;

    fetch_pc_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    fetch_pc_unit dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.im_rdata = mem(bus.im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic fault;
        fault = (m_pc[1:0] != 0) || (m_pc < IM_BASE) || (m_pc > IM_LIMIT);
        chk("PC_F", bus.PC_F, m_pc);
        chk("im_addr", bus.im_addr, m_pc);
        chk("PC_4F", bus.PC_4F, m_pc + 32'd4);
        chk("InstrF", bus.InstrF, fault ? 32'h0 : mem(m_pc));
        chk("ExcCodeF", {27'd0, bus.ExcCodeF}, fault ? 32'd4 : 32'd0);
        chk("if_bdF", {31'd0, bus.if_bdF}, {31'd0, m_bd & ~reset});
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fc);
        chk("stall_cnt", stall_cnt, m_sc);
`endif
    endtask

    task automatic drive(input logic r, input logic en, input logic red, input logic [31:0] rpc,
                         input logic jb, input logic exc, input logic eret, input logic [31:0] ep);
        reset = r; bus.EN = en; bus.redirect_D = red; bus.redirect_pc_D = rpc;
        bus.is_jb_D = jb; bus.exc_req = exc; bus.eret_req = eret; bus.epc = ep;
        @(posedge clk);
        if (r) begin
            m_pc = PC_RESET; m_bd = 0; m_fc = 0; m_sc = 0;
        end else if (exc) begin
            m_pc = EXC_ENTRY; m_bd = 0;
        end else if (eret) begin
            m_pc = ep; m_bd = 0;
        end else if (!en) begin
            m_sc = m_sc + 1;
        end else begin
            m_pc = red ? rpc : m_pc + 32'd4;
            m_bd = jb;
            m_fc = m_fc + 1;
        end
        #1 check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] t);
        drive(0, 1, 1, t, 1, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] rpc, held;
        m_pc = 0; m_bd = 0; m_fc = 0; m_sc = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h5000, 1, 1, 1, 32'h5555);
        chk("reset_pc", bus.PC_F, 32'h3000);
        run(3);
        chk("seq_pc", bus.PC_F, 32'h300C);
        run(1);
        held = bus.InstrF;
        drive(0, 0, 1, 32'h3500, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", bus.PC_F, 32'h3010);
        chk("stall_instr", bus.InstrF, held);
        run(1);
        chk("resume_pc", bus.PC_F, 32'h3014);
        run(3);
        jump(32'h3100);
        chk("redir_pc", bus.PC_F, 32'h3100);
        chk("redir_bd", {31'd0, bus.if_bdF}, 32'd1);
        run(1);
        chk("after_bd", {31'd0, bus.if_bdF}, 32'd0);
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stalled_bd", {31'd0, bus.if_bdF}, 32'd1);
        drive(0, 0, 1, 32'h3800, 1, 1, 0, 0);
        chk("exc_pc", bus.PC_F, 32'h4180);
        chk("exc_bd", {31'd0, bus.if_bdF}, 32'd0);
        drive(0, 1, 1, 32'h3900, 1, 0, 1, 32'h3024);
        chk("eret_pc", bus.PC_F, 32'h3024);
        drive(0, 1, 0, 0, 0, 1, 1, 32'h3abc);
        chk("exc_over_eret", bus.PC_F, 32'h4180);
        jump(32'h3002);
        chk("misalign_code", {27'd0, bus.ExcCodeF}, 32'd4);
        chk("misalign_instr", bus.InstrF, 32'h0);
        jump(32'h7000);
        chk("limit_code", {27'd0, bus.ExcCodeF}, 32'd4);
        jump(32'h6FFC);
        chk("top_ok_code", {27'd0, bus.ExcCodeF}, 32'd0);
        run(1);
        jump(32'h2FFC);
        run(1);
        jump(32'hFFFF_FFFC);
        run(1);
        chk("wrap_pc", bus.PC_F, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        run(5);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_fetch5", fetch_cnt, 32'd5);
        chk("cnt_stall3", stall_cnt, 32'd3);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("cnt_fetch_rst", fetch_cnt, 32'd0);
        chk("cnt_stall_rst", stall_cnt, 32'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rpc = IM_BASE + ($urandom_range(0, 4095) << 2);
                1: rpc = $urandom;
                2: rpc = IM_LIMIT - 32'd3 + $urandom_range(0, 7);
                default: rpc = IM_BASE - 32'd4 + $urandom_range(0, 8);
            endcase
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  rpc, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, IM_BASE + ($urandom_range(0, 4095) << 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
